// File: rtl/msgsend.sv
// rtl/msgsend.sv - response framer: buffers one response and serialises a CRC-protected frame to the UART TX
// Optional build macro: MSGSEND_SYNC_PREFIX_EN (leading SYNC_CHAR byte, 8-byte frames)

// Byte-wise CRC-16/CCITT (reflected) step shared with the receive-side checker
module msgsend_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [7:0] t0;
  logic [7:0] t1;

  // Fold one byte into the running CRC
  always_comb begin
    t0      = data_in ^ crc_in[7:0];
    t1      = t0 ^ {t0[3:0], 4'h0};
    crc_out = {t1, crc_in[15:8]} ^ {12'h000, t1[7:4]} ^ {5'b00000, t1, 3'b000};
  end

endmodule

module msgsend #(
  parameter logic [7:0] RESP_HDR  = 8'h72,
  parameter logic [7:0] SYNC_CHAR = 8'h7e
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_stb,
  input  logic [5:0] in_seq,
  input  logic [7:0] in_dat,
  output logic       in_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef MSGSEND_SYNC_PREFIX_EN
    S_PRE,
`endif
    S_HDR,
    S_SEQ,
    S_CNT,
    S_DAT,
    S_CRC0,
    S_CRC1,
    S_TERM,
    S_WAIT
  } state_t;

  // First byte state of every frame depends on whether the sync prefix is built in
`ifdef MSGSEND_SYNC_PREFIX_EN
  localparam state_t FIRST_STATE = S_PRE;
`else
  localparam state_t FIRST_STATE = S_HDR;
`endif

  state_t      state_q, state_d;
  logic        buf_full_q, buf_full_d;
  logic [5:0]  buf_seq_q, buf_seq_d;
  logic [7:0]  buf_dat_q, buf_dat_d;
  logic [5:0]  frm_seq_q, frm_seq_d;
  logic [7:0]  frm_dat_q, frm_dat_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_start_q, tx_start_d;

  logic        can_issue;
  logic        fold_crc;
  logic [7:0]  cur_byte;
  logic [15:0] crc_next;

  // A byte may start only when the UART is idle and the guard cycle after the last start has passed
  assign can_issue = !tx_busy && !tx_start_q;

  assign in_ready = !buf_full_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign busy_o   = (state_q != S_IDLE) || buf_full_q;

  // Select the byte belonging to the current frame position and whether it is CRC-covered
  always_comb begin
    cur_byte = 8'h00;
    fold_crc = 1'b0;
    case (state_q)
`ifdef MSGSEND_SYNC_PREFIX_EN
      S_PRE:  cur_byte = SYNC_CHAR;
`endif
      S_HDR:  begin cur_byte = RESP_HDR;           fold_crc = 1'b1; end
      S_SEQ:  begin cur_byte = {2'b00, frm_seq_q}; fold_crc = 1'b1; end
      S_CNT:  begin cur_byte = 8'h01;              fold_crc = 1'b1; end
      S_DAT:  begin cur_byte = frm_dat_q;          fold_crc = 1'b1; end
      S_CRC0: cur_byte = crc_q[15:8];
      S_CRC1: cur_byte = crc_q[7:0];
      S_TERM: cur_byte = SYNC_CHAR;
      default: cur_byte = 8'h00;
    endcase
  end

  msgsend_crc16 u_crc (
    .crc_in  (crc_q),
    .data_in (cur_byte),
    .crc_out (crc_next)
  );

  // Next-state logic: holding buffer capture, frame sequencing and byte issue
  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_seq_d  = buf_seq_q;
    buf_dat_d  = buf_dat_q;
    frm_seq_d  = frm_seq_q;
    frm_dat_d  = frm_dat_q;
    crc_d      = crc_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;

    // in_ready is the registered empty flag, so capture never coincides with a transfer
    if (in_stb && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_seq_d  = in_seq;
      buf_dat_d  = in_dat;
    end

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          frm_seq_d  = buf_seq_q;
          frm_dat_d  = buf_dat_q;
          crc_d      = 16'hffff;
          buf_full_d = 1'b0;
          state_d    = FIRST_STATE;
        end
      end
      S_WAIT: begin
        // Chain straight into the next buffered frame once the terminator has gone out
        if (can_issue) begin
          if (buf_full_q) begin
            frm_seq_d  = buf_seq_q;
            frm_dat_d  = buf_dat_q;
            crc_d      = 16'hffff;
            buf_full_d = 1'b0;
            state_d    = FIRST_STATE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
`ifdef MSGSEND_SYNC_PREFIX_EN
      S_PRE,
`endif
      S_HDR, S_SEQ, S_CNT, S_DAT, S_CRC0, S_CRC1, S_TERM: begin
        if (can_issue) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          if (fold_crc) begin
            crc_d = crc_next;
          end
          case (state_q)
`ifdef MSGSEND_SYNC_PREFIX_EN
            S_PRE:  state_d = S_HDR;
`endif
            S_HDR:  state_d = S_SEQ;
            S_SEQ:  state_d = S_CNT;
            S_CNT:  state_d = S_DAT;
            S_DAT:  state_d = S_CRC0;
            S_CRC0: state_d = S_CRC1;
            S_CRC1: state_d = S_TERM;
            default: state_d = S_WAIT;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any frame and drops the buffered response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      buf_full_q <= 1'b0;
      buf_seq_q  <= 6'h00;
      buf_dat_q  <= 8'h00;
      frm_seq_q  <= 6'h00;
      frm_dat_q  <= 8'h00;
      crc_q      <= 16'hffff;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_seq_q  <= buf_seq_d;
      buf_dat_q  <= buf_dat_d;
      frm_seq_q  <= frm_seq_d;
      frm_dat_q  <= frm_dat_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
    end
  end

endmodule

// File: tb/tb_msgsend.sv
// tb/tb_msgsend.sv - self-checking bench for msgsend with a UART TX model and frame reference model

module tb_msgsend;

`ifdef MSGSEND_SYNC_PREFIX_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_stb = 1'b0;
  logic [5:0] in_seq = 6'h00;
  logic [7:0] in_dat = 8'h00;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       busy_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  int len_min = 10;
  int len_max = 10;
  int lat_mode = 1;
  int busy_cnt = 0;
  bit busy_pend = 1'b0;
  bit prev_start = 1'b0;
  bit start_now = 1'b0;
  int cur_len = 0;

  always #5 clk = ~clk;

  msgsend dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_stb   (in_stb),
    .in_seq   (in_seq),
    .in_dat   (in_dat),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .busy_o   (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference frame: bytes from the frame layout, CRC computed bit-serially (reflected poly 0x8408)
  function automatic void push_frame(input logic [5:0] s, input logic [7:0] d);
    logic [7:0]  body[4];
    logic [15:0] c;
    c = 16'hffff;
    body[0] = 8'h72;
    body[1] = {2'b00, s};
    body[2] = 8'h01;
    body[3] = d;
`ifdef MSGSEND_SYNC_PREFIX_EN
    exp_q.push_back(8'h7e);
`endif
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(body[i]);
      c = c ^ {8'h00, body[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(8'h7e);
  endfunction

  // UART TX model: samples tx_start mid-cycle, raises busy with 0 or 1 cycle latency
  always @(negedge clk) begin
    start_now = tx_start;
    if (start_now === 1'b1) begin
      check("start_while_busy", 32'(tx_busy), 0);
      check("start_back_to_back", 32'(prev_start), 0);
      got.push_back(tx_data);
    end
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) tx_busy = 1'b0;
    end
    if (busy_pend) begin
      busy_pend = 1'b0;
      tx_busy   = 1'b1;
      busy_cnt  = cur_len;
    end
    if (start_now === 1'b1) begin
      cur_len = $urandom_range(len_max, len_min);
      if (lat_mode == 0 || (lat_mode == 2 && $urandom_range(1, 0) == 0)) begin
        tx_busy  = 1'b1;
        busy_cnt = cur_len;
      end else begin
        busy_pend = 1'b1;
      end
    end
    prev_start = start_now;
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic send(input logic [5:0] s, input logic [7:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    check("send_ready_timeout", 32'(n < 400), 1);
    in_stb = 1'b1;
    in_seq = s;
    in_dat = d;
    tick();
    in_stb = 1'b0;
    push_frame(s, d);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((got.size() < exp_q.size() || busy_o || tx_busy) && n < 3000) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < 3000), 1);
  endtask

  task automatic compare_stream(input string tag);
    int m;
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < m; i++) check({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_n = 1'b1;
    tick();

    // Single response with latency check; busy rises one cycle after tx_start
    len_min = 10; len_max = 10; lat_mode = 1;
    in_stb = 1'b1; in_seq = 6'h05; in_dat = 8'hab;
    tick();
    in_stb = 1'b0;
    push_frame(6'h05, 8'hab);
    check("acc_in_ready_low", 32'(in_ready), 0);
    check("acc_busy_high", 32'(busy_o), 1);
    tick();
    check("lat_cycle1_no_start", 32'(tx_start), 0);
    tick();
    check("lat_cycle2_start", 32'(tx_start), 1);
    check("lat_first_byte", 32'(tx_data), 32'(exp_q[0]));
    wait_idle();
    compare_stream("single");

    // Back-to-back responses, busy rises in the start cycle
    lat_mode = 0; len_min = 4; len_max = 8;
    send(6'h01, 8'h00);
    send(6'h02, 8'hff);
    check("b2b_second_during_first", 32'(got.size() < FLEN), 1);
    check("b2b_busy", 32'(busy_o), 1);
    wait_idle();
    compare_stream("b2b");

    // Backpressure: strobe with seq 3f while the buffer is occupied
    lat_mode = 1; len_min = 10; len_max = 10;
    send(6'h11, 8'h22);
    send(6'h3c, 8'h66);
    for (int i = 0; i < 10; i++) begin
      check("bp_in_ready_low", 32'(in_ready), 0);
      in_stb = 1'b1; in_seq = 6'h3f; in_dat = 8'h55;
      tick();
    end
    in_stb = 1'b0;
    wait_idle();
    repeat (20) tick();
    compare_stream("backpressure");

    // Randomized responses, gaps and TX timing
    lat_mode = 2; len_min = 1; len_max = 6;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(3, 0)) tick();
      send(6'($urandom), 8'($urandom));
    end
    wait_idle();
    compare_stream("random");

    // Reset mid-frame after three bytes, with a second response buffered
    lat_mode = 1; len_min = 10; len_max = 10;
    send(6'h09, 8'h12);
    send(6'h0a, 8'h34);
    n = 0;
    while (got.size() < 3 && n < 400) begin
      tick();
      n++;
    end
    check("mid_three_bytes", 32'(got.size()), 3);
    rst_n = 1'b0;
    repeat (3) tick();
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_tx_start", 32'(tx_start), 0);
    rst_n = 1'b1;
    repeat (60) tick();
    check("mid_no_more_bytes", 32'(got.size()), 3);
    check("mid_idle_after", 32'(busy_o), 0);
    got.delete();
    exp_q.delete();
    send(6'h15, 8'h5a);
    wait_idle();
    compare_stream("after_reset");

    // Zero response (prefix build checks leading 7e,72 via the reference)
    send(6'h00, 8'h00);
    wait_idle();
    compare_stream("zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
